// File: rtl/frame_tx1101_pkg.sv
// Shared constants and types for the 1101 serial frame transmitter.
package frame1101_pkg;

    localparam logic [3:0] SYNC_PATTERN = 4'b1101;
    localparam int         SYNC_LEN     = 4;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        PAR,
        GAP
    } state_t;

    // Sync bit at position idx, counted from the first bit sent (MSB first).
    function automatic logic sync_bit(input logic [1:0] idx);
        return SYNC_PATTERN[2'd3 - idx];
    endfunction

endpackage

// File: rtl/frame_tx1101_if.sv
// Parallel payload handshake between a word producer and the frame transmitter.
interface frame_tx1101_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;

    modport master (output din, output din_valid, input  din_ready);
    modport slave  (input  din, input  din_valid, output din_ready);
endinterface

// File: rtl/frame_tx1101.sv
// Serial frame transmitter: sync 1101, payload MSB first, optional even
// parity, then a forced-low idle gap. One bit per clock on txd.
module frame_tx1101
    import frame1101_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit PARITY_EN = 1'b1,
    parameter int GAP_CYC   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    frame_tx1101_if.slave        bus,
    output logic                 txd,
    output logic                 busy,
    output logic                 done
);

    // Wide enough for DATA_W up to 32, GAP_CYC up to 15 and the sync length.
    localparam int CNT_W = 6;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_q,   par_d;
    logic                txd_q,   txd_d;
    logic                done_q,  done_d;

    logic                ready;
    logic                hs;

    // Ready only while idle and enabled; rst forces it low immediately.
    assign ready         = (state_q == IDLE) & en & ~rst;
    assign hs            = ready & bus.din_valid;
    assign bus.din_ready = ready;

    assign txd  = txd_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

    // Next-state logic: txd_d/done_d describe the bit shown after this edge.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = 1'b0;
        done_d  = 1'b0;

        if (!en) begin
            // Abort: drop the partial frame, no done pulse, word not retried.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hs) begin
                        state_d = SYNC;
                        cnt_d   = '0;
                        shift_d = bus.din;
                        par_d   = ^bus.din;
                        txd_d   = sync_bit(2'd0);
                    end
                end

                SYNC: begin
                    if (cnt_q == CNT_W'(SYNC_LEN - 1)) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        txd_d   = shift_q[DATA_W-1];
                        shift_d = shift_q << 1;
                        done_d  = (DATA_W == 1) && !PARITY_EN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        txd_d = sync_bit(cnt_q[1:0] + 2'd1);
                    end
                end

                DATA: begin
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d = '0;
                        if (PARITY_EN) begin
                            state_d = PAR;
                            txd_d   = par_q;
                            done_d  = 1'b1;
                        end else if (GAP_CYC > 0) begin
                            state_d = GAP;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        txd_d   = shift_q[DATA_W-1];
                        shift_d = shift_q << 1;
                        // Without parity the final payload bit closes the frame.
                        done_d  = !PARITY_EN && (cnt_q == CNT_W'(DATA_W - 2));
                    end
                end

                PAR: begin
                    cnt_d   = '0;
                    state_d = (GAP_CYC > 0) ? GAP : IDLE;
                end

                GAP: begin
                    if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and registered outputs; async reset clears everything including the shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops sample pre-edge values together.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_frame_tx1101.sv
// Self-checking bench for frame_tx1101: directed and random frames on a
// parity/gap-2 instance and a no-parity/gap-1 instance, with en abort and
// asynchronous reset cases.
module tb_frame_tx1101;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic txd0, busy0, done0;
    logic txd1, busy1, done1;

    int checks = 0;
    int errors = 0;

    frame_tx1101_if #(.DATA_W(8)) bus0 ();
    frame_tx1101_if #(.DATA_W(8)) bus1 ();

    frame_tx1101 #(.DATA_W(8), .PARITY_EN(1'b1), .GAP_CYC(2)) u_dut0 (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .bus  (bus0.slave),
        .txd  (txd0),
        .busy (busy0),
        .done (done0)
    );

    frame_tx1101 #(.DATA_W(8), .PARITY_EN(1'b0), .GAP_CYC(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .bus  (bus1.slave),
        .txd  (txd1),
        .busy (busy1),
        .done (done1)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Bit i of the serial frame for word w: sync, payload MSB first, even parity.
    function automatic logic model_bit(input logic [7:0] w, input bit par_en, input int i);
        logic [3:0] sync;
        sync = 4'b1101;
        if (i < 4)  return sync[3-i];
        if (i < 12) return w[11-i];
        if (par_en) return ($countones(w) % 2) == 1;
        return 1'b0;
    endfunction

    function automatic int model_len(input int s);
        return (s == 0) ? 13 : 12;
    endfunction

    function automatic int model_gap(input int s);
        return (s == 0) ? 2 : 1;
    endfunction

    // ---------------- per-instance access ----------------
    function automatic logic get_txd(input int s);   return (s == 0) ? txd0 : txd1;   endfunction
    function automatic logic get_busy(input int s);  return (s == 0) ? busy0 : busy1; endfunction
    function automatic logic get_done(input int s);  return (s == 0) ? done0 : done1; endfunction
    function automatic logic get_ready(input int s);
        return (s == 0) ? bus0.din_ready : bus1.din_ready;
    endfunction

    task automatic drive(input int s, input logic v, input logic [7:0] w);
        if (s == 0) begin
            bus0.din_valid = v;
            bus0.din       = w;
        end else begin
            bus1.din_valid = v;
            bus1.din       = w;
        end
    endtask

    // Called at a negedge: offer w and wait (bounded) for the handshake edge.
    // Without hold, valid drops and din is scrambled right after the edge.
    task automatic offer(input int s, input logic [7:0] w, input bit hold);
        int k;
        k = 0;
        drive(s, 1'b1, w);
        #1;
        while (!get_ready(s) && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        check($sformatf("handshake_wait_dut%0d", s), 32'(k < 40), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) drive(s, 1'b0, 8'($urandom));
    endtask

    // Frame bits sampled on the negedges following the handshake edge.
    task automatic expect_frame(input int s, input logic [7:0] w, input string tag);
        int len;
        len = model_len(s);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            check($sformatf("%s_txd%0d", tag, i), 32'(get_txd(s)), 32'(model_bit(w, s == 0, i)));
            check($sformatf("%s_done%0d", tag, i), 32'(get_done(s)), 32'(i == len - 1));
            check($sformatf("%s_busy%0d", tag, i), 32'(get_busy(s)), 32'd1);
        end
    endtask

    // Gap cycles (busy, not ready, low line) then one idle cycle that is ready.
    task automatic expect_tail(input int s, input string tag);
        for (int g = 0; g < model_gap(s); g++) begin
            @(negedge clk);
            check($sformatf("%s_gap_txd%0d", tag, g), 32'(get_txd(s)), 32'd0);
            check($sformatf("%s_gap_busy%0d", tag, g), 32'(get_busy(s)), 32'd1);
            check($sformatf("%s_gap_ready%0d", tag, g), 32'(get_ready(s)), 32'd0);
            check($sformatf("%s_gap_done%0d", tag, g), 32'(get_done(s)), 32'd0);
        end
        @(negedge clk);
        check($sformatf("%s_idle_busy", tag), 32'(get_busy(s)), 32'd0);
        check($sformatf("%s_idle_ready", tag), 32'(get_ready(s)), 32'd1);
        check($sformatf("%s_idle_txd", tag), 32'(get_txd(s)), 32'd0);
    endtask

    // Two words with valid held high: exactly 1+gap low cycles between frames.
    task automatic back_to_back(input int s, input logic [7:0] a, input logic [7:0] b, input string tag);
        offer(s, a, 1'b1);
        drive(s, 1'b1, b);
        expect_frame(s, a, {tag, "_a"});
        for (int g = 0; g < model_gap(s) + 1; g++) begin
            @(negedge clk);
            check($sformatf("%s_sep_txd%0d", tag, g), 32'(get_txd(s)), 32'd0);
        end
        @(posedge clk);
        #1;
        drive(s, 1'b0, 8'($urandom));
        expect_frame(s, b, {tag, "_b"});
        expect_tail(s, {tag, "_b"});
    endtask

    initial begin
        logic [7:0] w;

        rst = 1'b1;
        en  = 1'b1;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);

        // Reset state
        #12;
        check("rst_txd0",   32'(txd0),           32'd0);
        check("rst_busy0",  32'(busy0),          32'd0);
        check("rst_done0",  32'(done0),          32'd0);
        check("rst_ready0", 32'(bus0.din_ready), 32'd0);
        check("rst_txd1",   32'(txd1),           32'd0);
        check("rst_ready1", 32'(bus1.din_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready0", 32'(bus0.din_ready), 32'd1);
        @(negedge clk);

        // Directed frames
        offer(0, 8'hA5, 1'b0);
        expect_frame(0, 8'hA5, "a5");
        expect_tail(0, "a5");

        offer(0, 8'h07, 1'b0);
        expect_frame(0, 8'h07, "h07");
        expect_tail(0, "h07");

        back_to_back(0, 8'hA5, 8'h3C, "b2b0");

        // Random frames, parity instance
        for (int n = 0; n < 16; n++) begin
            w = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            offer(0, w, 1'b0);
            expect_frame(0, w, $sformatf("rnd0_%0d", n));
            expect_tail(0, $sformatf("rnd0_%0d", n));
        end

        // No-parity instance: 12-bit frames, done on din[0]
        for (int n = 0; n < 8; n++) begin
            w = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            offer(1, w, 1'b0);
            expect_frame(1, w, $sformatf("rnd1_%0d", n));
            expect_tail(1, $sformatf("rnd1_%0d", n));
        end
        back_to_back(1, 8'($urandom), 8'($urandom), "b2b1");

        // en dropped during the 3rd payload bit
        w = 8'($urandom);
        offer(0, w, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check($sformatf("abort_txd%0d", i), 32'(txd0), 32'(model_bit(w, 1'b1, i)));
        end
        en = 1'b0;
        @(negedge clk);
        check("abort_txd",   32'(txd0),           32'd0);
        check("abort_busy",  32'(busy0),          32'd0);
        check("abort_ready", 32'(bus0.din_ready), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("abort_nodone%0d", i), 32'(done0 | busy0 | txd0), 32'd0);
        end
        en = 1'b1;
        #1;
        check("abort_ready_back", 32'(bus0.din_ready), 32'd1);
        @(negedge clk);
        check("abort_no_retry", 32'(busy0), 32'd0);

        // Async reset pulsed mid-SYNC, between clock edges
        offer(0, 8'($urandom), 1'b0);
        @(negedge clk);
        @(posedge clk);
        #2;
        check("pre_rst_txd", 32'(txd0), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_txd",  32'(txd0),  32'd0);
        check("async_rst_busy", 32'(busy0), 32'd0);
        check("async_rst_done", 32'(done0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        w = 8'($urandom);
        offer(0, w, 1'b0);
        expect_frame(0, w, "after_rst");
        expect_tail(0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
